// File: rtl/amm_pipe_bridge.sv
// Avalon-MM pipeline bridge: command FIFO toward the downstream slave, credit-limited
// read tracking, and a registered read-response path back upstream.
module amm_pipe_bridge #(
  parameter int A_W       = 32,
  parameter int D_W       = 64,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_PEND  = 8,
  parameter int BURST_EN  = 0,
  parameter int BURST_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_W-1:0]     s_address,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [D_W-1:0]     s_writedata,
  input  logic [D_W/8-1:0]   s_byteenable,
  input  logic [BURST_W-1:0] s_burstcount,
  output logic               s_waitrequest,
  output logic [D_W-1:0]     s_readdata,
  output logic               s_readdatavalid,
  output logic [A_W-1:0]     m_address,
  output logic               m_read,
  output logic               m_write,
  output logic [D_W-1:0]     m_writedata,
  output logic [D_W/8-1:0]   m_byteenable,
  output logic [BURST_W-1:0] m_burstcount,
  input  logic               m_waitrequest,
  input  logic [D_W-1:0]     m_readdata,
  input  logic               m_readdatavalid
);

  localparam int BE_W   = D_W / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int SUM_W  = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);
  localparam logic [SUM_W-1:0] MAXP_C  = SUM_W'(MAX_PEND);
  localparam bit BURST_ON = (BURST_EN != 32'sd0);

  logic               r_q_rd    [CMD_DEPTH];
  logic               r_q_wr    [CMD_DEPTH];
  logic [A_W-1:0]     r_q_addr  [CMD_DEPTH];
  logic [D_W-1:0]     r_q_wdata [CMD_DEPTH];
  logic [BE_W-1:0]    r_q_be    [CMD_DEPTH];
  logic [BURST_W-1:0] r_q_bc    [CMD_DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PEND_W-1:0] r_pend;
  logic              r_s_rvalid;
  logic [D_W-1:0]    r_s_rdata;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_rd_acc;
  logic               w_credit_short;
  logic               w_beat_ok;
  logic [SUM_W-1:0]   w_bc;
  logic [SUM_W-1:0]   w_pend_ext;
  logic [PEND_W-1:0]  w_pend_nxt;
  logic [BURST_W-1:0] w_bc_store;

  assign w_empty    = (r_count == {CNT_W{1'b0}});
  assign w_full     = (r_count == DEPTH_C);
  assign w_pend_ext = SUM_W'(r_pend);

  // Credit cost of the offered read; a zero burstcount is charged as one beat
  always_comb begin
    w_bc       = SUM_W'(1'b1);
    w_bc_store = BURST_W'(1'b1);
    if (BURST_ON) begin
      w_bc_store = s_burstcount;
      if (s_burstcount != {BURST_W{1'b0}}) begin
        w_bc = SUM_W'(s_burstcount);
      end else begin
        w_bc = SUM_W'(1'b1);
      end
    end else begin
      w_bc       = SUM_W'(1'b1);
      w_bc_store = BURST_W'(1'b1);
    end
  end

  assign w_credit_short  = ((w_pend_ext + w_bc) > MAXP_C);
  assign s_waitrequest   = rst | w_full | (s_read & w_credit_short);
  assign w_push          = (s_read | s_write) & ~s_waitrequest;
  assign w_rd_acc        = s_read & ~s_waitrequest;
  assign w_pop           = (m_read | m_write) & ~m_waitrequest;
  // A beat already heading upstream has consumed its credit even before pend drops
  assign w_beat_ok       = m_readdatavalid & (r_pend > PEND_W'(r_s_rvalid));
  assign w_pend_nxt      = r_pend + (w_rd_acc ? PEND_W'(w_bc) : {PEND_W{1'b0}})
                           - PEND_W'(r_s_rvalid);
  assign s_readdatavalid = r_s_rvalid;
  assign s_readdata      = r_s_rdata;

  // Command storage write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]    <= s_read;
      r_q_wr[r_wr_ptr]    <= s_write;
      r_q_addr[r_wr_ptr]  <= s_address;
      r_q_wdata[r_wr_ptr] <= s_writedata;
      r_q_be[r_wr_ptr]    <= s_byteenable;
      r_q_bc[r_wr_ptr]    <= w_bc_store;
    end
  end

  // Head of FIFO drives the downstream command; empty FIFO presents all zeros
  always_comb begin
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = {A_W{1'b0}};
    m_writedata  = {D_W{1'b0}};
    m_byteenable = {BE_W{1'b0}};
    m_burstcount = {BURST_W{1'b0}};
    if (!w_empty) begin
      m_read       = r_q_rd[r_rd_ptr];
      m_write      = r_q_wr[r_rd_ptr];
      m_address    = r_q_addr[r_rd_ptr];
      m_writedata  = r_q_wdata[r_rd_ptr];
      m_byteenable = r_q_be[r_rd_ptr];
      m_burstcount = r_q_bc[r_rd_ptr];
    end else begin
      m_read  = 1'b0;
      m_write = 1'b0;
    end
  end

  // FIFO pointers, occupancy and outstanding read credit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_pend   <= {PEND_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1'b1);
        2'b01:   r_count <= r_count - CNT_W'(1'b1);
        default: r_count <= r_count;
      endcase
      r_pend <= w_pend_nxt;
    end
  end

  // Registered read response toward the upstream master
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_rvalid <= 1'b0;
      r_s_rdata  <= {D_W{1'b0}};
    end else begin
      r_s_rvalid <= w_beat_ok;
      r_s_rdata  <= m_readdata;
    end
  end

endmodule
